tetris_vram_writer: RTL and testbench



---
 rtl/tetris_pkg.sv | 32 +++
 rtl/bin2bcd_seq.sv | 74 +++++++
 rtl/tetris_vram_writer.sv | 172 +++++++++++++++++
 tb/tb_tetris_vram_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris VRAM writer, renderer and game FSM.
package tetris_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StConvert,
    StFetch,
    StWrOcc,
    StWrCol,
    StWrSc0,
    StWrSc1,
    StWrSt,
    StFin
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  localparam int unsigned DEF_COLOR_BASE = 40;
  localparam int unsigned DEF_STATE_ADDR = 100;
  localparam int unsigned DEF_SCORE_ADDR = 102;

  localparam int unsigned SCORE_MAX = 999999;

  localparam logic [1:0] GS_TITLE   = 2'd0;
  localparam logic [1:0] GS_PLAYING = 2'd1;
  localparam logic [1:0] GS_OVER    = 2'd2;

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, SCORE_W cycles, six BCD digits out.
module bin2bcd_seq
  import tetris_pkg::*;
#(
  parameter int unsigned SCORE_W = 20
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [SCORE_W-1:0] bin_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [23:0]        bcd_o
);

  localparam int unsigned CntW = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] bin_q, bin_d, clamped;
  logic [23:0]        bcd_q, bcd_d;
  logic [22:0]        adj;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;

  // done_o flags the cycle whose closing edge performs the final shift.
  assign done_o = busy_q && (cnt_q == CntW'(SCORE_W - 1));
  assign busy_o = busy_q;
  assign bcd_o  = bcd_q;

  always_comb begin
    clamped = bin_i;
    if (64'(bin_i) > 64'(SCORE_MAX)) clamped = SCORE_W'(SCORE_MAX);
  end

  // The clamp keeps the top digit below 5 before every shift, so it never needs adjusting.
  always_comb begin
    adj = bcd_q[22:0];
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      bin_d  = clamped;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {adj, bin_q[SCORE_W-1]};
      bin_d = {bin_q[SCORE_W-2:0], 1'b0};
      cnt_d = cnt_q + CntW'(1);
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/tetris_vram_writer.sv
// Avalon-MM master copying board rows, score digits and game state into text-mode VRAM.
module tetris_vram_writer
  import tetris_pkg::*;
#(
  parameter int unsigned ROWS       = 20,
  parameter int unsigned COLOR_BASE = DEF_COLOR_BASE,
  parameter int unsigned STATE_ADDR = DEF_STATE_ADDR,
  parameter int unsigned SCORE_ADDR = DEF_SCORE_ADDR,
  parameter int unsigned SCORE_W    = 20
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               UPDATE,
  input  logic [SCORE_W-1:0] SCORE,
  input  logic [1:0]         GAME_STATE,
  output logic [4:0]         BOARD_ROW,
  input  logic [9:0]         BOARD_OCC,
  input  logic [29:0]        BOARD_COLOR,
  output logic               AVM_WRITE,
  output logic [11:0]        AVM_ADDR,
  output logic [31:0]        AVM_WRITEDATA,
  output logic [3:0]         AVM_BYTE_EN,
  input  logic               AVM_WAITREQUEST,
  output logic               BUSY,
  output logic               DONE
);

  state_e      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [9:0]  occ_q, occ_d;
  logic [29:0] color_q, color_d;
  logic [1:0]  gs_q, gs_d;
  logic        pending_q, pending_d;
  logic        write_q, write_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;
  logic        bcd_busy, bcd_done;
  logic [23:0] bcd;

  assign accept = ((state_q == StIdle) && UPDATE) ||
                  ((state_q == StFin) && (pending_q || UPDATE));

  bin2bcd_seq #(
    .SCORE_W (SCORE_W)
  ) u_bin2bcd (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .start_i (accept),
    .bin_i   (SCORE),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (UPDATE) state_d = StConvert;
      StConvert: if (bcd_busy && bcd_done) state_d = StFetch;
      StFetch:   state_d = StWrOcc;
      StWrOcc:   if (!AVM_WAITREQUEST) state_d = StWrCol;
      StWrCol:   if (!AVM_WAITREQUEST) state_d = (row_q == 5'(ROWS - 1)) ? StWrSc0 : StFetch;
      StWrSc0:   if (!AVM_WAITREQUEST) state_d = StWrSc1;
      StWrSc1:   if (!AVM_WAITREQUEST) state_d = StWrSt;
      StWrSt:    if (!AVM_WAITREQUEST) state_d = StFin;
      StFin:     state_d = (pending_q || UPDATE) ? StConvert : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Requests arriving mid-frame collapse into one pending re-run.
  always_comb begin
    row_d     = row_q;
    occ_d     = occ_q;
    color_d   = color_q;
    gs_d      = gs_q;
    pending_d = pending_q;
    if (accept) begin
      row_d     = '0;
      gs_d      = GAME_STATE;
      pending_d = 1'b0;
    end else if ((state_q != StIdle) && UPDATE) begin
      pending_d = 1'b1;
    end
    if (state_q == StFetch) begin
      occ_d   = BOARD_OCC;
      color_d = BOARD_COLOR;
    end
    if ((state_q == StWrCol) && (state_d == StFetch)) row_d = row_q + 5'd1;
  end

  // Outputs are decoded from the next state and registered, so they hold steady under stalls.
  always_comb begin
    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StFin);
    unique case (state_d)
      StWrOcc: begin
        write_d = 1'b1;
        addr_d  = 12'(row_d);
        data_d  = {22'b0, occ_d};
      end
      StWrCol: begin
        write_d = 1'b1;
        addr_d  = 12'(COLOR_BASE) + 12'(row_d);
        data_d  = {2'b0, color_d};
      end
      StWrSc0: begin
        write_d = 1'b1;
        addr_d  = 12'(SCORE_ADDR);
        data_d  = {bcd_to_ascii(bcd[11:8]), bcd_to_ascii(bcd[15:12]),
                   bcd_to_ascii(bcd[19:16]), bcd_to_ascii(bcd[23:20])};
      end
      StWrSc1: begin
        write_d = 1'b1;
        addr_d  = 12'(SCORE_ADDR + 1);
        data_d  = {16'h0, bcd_to_ascii(bcd[3:0]), bcd_to_ascii(bcd[7:4])};
      end
      StWrSt: begin
        write_d = 1'b1;
        addr_d  = 12'(STATE_ADDR);
        data_d  = {30'b0, gs_d};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      row_q     <= '0;
      occ_q     <= '0;
      color_q   <= '0;
      gs_q      <= '0;
      pending_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      occ_q     <= occ_d;
      color_q   <= color_d;
      gs_q      <= gs_d;
      pending_q <= pending_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign BOARD_ROW     = row_q;
  assign AVM_WRITE     = write_q;
  assign AVM_ADDR      = addr_q;
  assign AVM_WRITEDATA = data_q;
  assign AVM_BYTE_EN   = 4'hF;
  assign BUSY          = busy_q;
  assign DONE          = done_q;

endmodule

// File: tb/tb_tetris_vram_writer.sv
// Scoreboard bench: expected VRAM writes are queued per frame and popped as writes are accepted.
module tb_tetris_vram_writer;
  import tetris_pkg::*;

  localparam int unsigned SCORE_W = 20;
  localparam int unsigned ROWS    = 20;

  logic               CLK = 1'b0;
  logic               RESET_N = 1'b0;
  logic               UPDATE = 1'b0;
  logic [SCORE_W-1:0] SCORE = '0;
  logic [1:0]         GAME_STATE = '0;
  logic [4:0]         BOARD_ROW;
  logic [9:0]         BOARD_OCC;
  logic [29:0]        BOARD_COLOR;
  logic               AVM_WRITE;
  logic [11:0]        AVM_ADDR;
  logic [31:0]        AVM_WRITEDATA;
  logic [3:0]         AVM_BYTE_EN;
  logic               AVM_WAITREQUEST = 1'b0;
  logic               BUSY;
  logic               DONE;

  logic [9:0]  occ_mem [32];
  logic [29:0] col_mem [32];
  logic [43:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  assign BOARD_OCC   = occ_mem[BOARD_ROW];
  assign BOARD_COLOR = col_mem[BOARD_ROW];

  always #10 CLK = ~CLK;

  tetris_vram_writer #(
    .ROWS       (ROWS),
    .COLOR_BASE (40),
    .STATE_ADDR (100),
    .SCORE_ADDR (102),
    .SCORE_W    (SCORE_W)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .UPDATE          (UPDATE),
    .SCORE           (SCORE),
    .GAME_STATE      (GAME_STATE),
    .BOARD_ROW       (BOARD_ROW),
    .BOARD_OCC       (BOARD_OCC),
    .BOARD_COLOR     (BOARD_COLOR),
    .AVM_WRITE       (AVM_WRITE),
    .AVM_ADDR        (AVM_ADDR),
    .AVM_WRITEDATA   (AVM_WRITEDATA),
    .AVM_BYTE_EN     (AVM_BYTE_EN),
    .AVM_WAITREQUEST (AVM_WAITREQUEST),
    .BUSY            (BUSY),
    .DONE            (DONE)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected frame: rows, colours, score words, then state word.
  task automatic push_frame(input int unsigned score, input logic [1:0] gs);
    int unsigned s;
    logic [7:0]  a [6];
    s = (score > 999999) ? 999999 : score;
    for (int i = 0; i < 6; i++) begin
      a[i] = 8'h30 + 8'(s % 10);
      s    = s / 10;
    end
    for (int r = 0; r < int'(ROWS); r++) begin
      exp_q.push_back({12'(r), {22'b0, occ_mem[r]}});
      exp_q.push_back({12'(40 + r), {2'b0, col_mem[r]}});
    end
    exp_q.push_back({12'd102, {a[2], a[3], a[4], a[5]}});
    exp_q.push_back({12'd103, {16'h0, a[0], a[1]}});
    exp_q.push_back({12'd100, {30'b0, gs}});
  endtask

  always @(negedge CLK) begin
    if (RESET_N && AVM_WRITE && !AVM_WAITREQUEST) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [43:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(AVM_ADDR), 64'(e[43:32]));
        check("wr_data", 64'(AVM_WRITEDATA), 64'(e[31:0]));
      end
    end
  end

  task automatic start_pass(input int unsigned score, input logic [1:0] gs);
    @(posedge CLK);
    #1;
    SCORE      = SCORE_W'(score);
    GAME_STATE = gs;
    push_frame(score, gs);
    UPDATE     = 1'b1;
    @(posedge CLK);
    #1;
    UPDATE     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (n == 1) check("busy_rise", 64'(BUSY), 64'd1);
    end while (!DONE && n < 400);
    check(tag, 64'(n), 64'(exp_lat));
  endtask

  task automatic pulse_update();
    @(posedge CLK);
    #1;
    UPDATE = 1'b1;
    @(posedge CLK);
    #1;
    UPDATE = 1'b0;
  endtask

  task automatic wait_write_addr(input logic [11:0] addr);
    int n;
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (!(AVM_WRITE && AVM_ADDR == addr) && n < 300);
  endtask

  task automatic stall_row3();
    wait_write_addr(12'd3);
    AVM_WAITREQUEST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_wr", 64'(AVM_WRITE), 64'd1);
      check("stall_addr", 64'(AVM_ADDR), 64'd3);
      check("stall_data", 64'(AVM_WRITEDATA), 64'({22'b0, occ_mem[3]}));
    end
    @(posedge CLK);
    #1;
    AVM_WAITREQUEST = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int extra;
    for (int r = 0; r < 32; r++) begin
      occ_mem[r] = '0;
      col_mem[r] = '0;
    end
    repeat (3) @(negedge CLK);
    check("rst_write", 64'(AVM_WRITE), 64'd0);
    check("rst_addr", 64'(AVM_ADDR), 64'd0);
    check("rst_data", 64'(AVM_WRITEDATA), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_row", 64'(BOARD_ROW), 64'd0);
    check("byte_en", 64'(AVM_BYTE_EN), 64'hF);
    RESET_N = 1'b1;

    // Empty board, score 1234, playing.
    start_pass(1234, GS_PLAYING);
    wait_done("done_lat", 84);

    // Random board with row 19 corner pattern; score above 20-bit saturation point.
    for (int r = 0; r < int'(ROWS); r++) begin
      occ_mem[r] = 10'($urandom);
      col_mem[r] = 30'($urandom);
    end
    occ_mem[19] = 10'h201;
    col_mem[19] = 30'h3800_0001;
    start_pass(32'hFFFFF, GS_OVER);
    wait_done("done_sat", 84);

    // Five stalled cycles on row 3 occupancy write.
    occ_mem[3] = 10'h2AA;
    start_pass(42, GS_TITLE);
    fork
      wait_done("done_stall", 89);
      stall_row3();
    join

    // Three requests while busy merge into one re-run with the new snapshot.
    start_pass(999999, GS_PLAYING);
    fork
      wait_done("done_pass1", 84);
      begin
        repeat (5) @(posedge CLK);
        #1;
        SCORE      = SCORE_W'(1000000);
        GAME_STATE = GS_OVER;
        push_frame(1000000, GS_OVER);
        UPDATE = 1'b1;
        @(posedge CLK);
        #1;
        UPDATE = 1'b0;
        repeat (20) @(posedge CLK);
        pulse_update();
        repeat (20) @(posedge CLK);
        pulse_update();
      end
    join
    wait_done("done_pass2", 84);
    extra = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge CLK);
      if (DONE) extra++;
    end
    check("no_third_pass", 64'(extra), 64'd0);
    check("idle_busy", 64'(BUSY), 64'd0);

    // Reset during row 7 colour write with a request pending.
    start_pass(555, GS_PLAYING);
    pulse_update();
    wait_write_addr(12'd47);
    RESET_N = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_write", 64'(AVM_WRITE), 64'd0);
    check("rst_mid_busy", 64'(BUSY), 64'd0);
    check("rst_mid_addr", 64'(AVM_ADDR), 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (10) @(negedge CLK);
    check("rst_pend_clr", 64'(BUSY), 64'd0);
    start_pass(7, 2'd3);
    wait_done("done_recover", 84);

    repeat (5) @(negedge CLK);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
